// File: rtl/rv64g_l2_dir_update.sv
// L2 directory update engine: zero-sweeps the directory after reset, then applies
// one coherence op per request as a read-modify-write of a single way's entry.
module rv64g_l2_dir_update #(
  parameter int SETS  = 256,
  parameter int WAYS  = 16,
  parameter int CORES = 4,
  localparam int OW = $clog2(CORES),
  localparam int SW = $clog2(SETS),
  localparam int WW = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Both handshakes: a beat transfers on a rising edge where valid && ready;
  // the producer holds valid and its payload stable until that edge.
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [SW-1:0]         req_set_i,
  input  logic [WW-1:0]         req_way_i,
  input  logic [2:0]            req_op_i,
  input  logic [OW-1:0]         req_core_i,
  input  logic                  req_dirty_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_valid_st_o,
  output logic [CORES-1:0]      rsp_sharers_o,
  output logic                  rsp_owner_valid_o,
  output logic [OW-1:0]         rsp_owner_id_o,
  output logic                  rsp_dirty_o,
  output logic                  rsp_err_o,
  output logic                  init_done_o,
  output logic [SW-1:0]         dir_rd_set_o,
  input  logic [WAYS-1:0]       dir_rd_valid_i,
  input  logic [WAYS*CORES-1:0] dir_rd_sharers_i,
  input  logic [WAYS-1:0]       dir_rd_owner_valid_i,
  input  logic [WAYS*OW-1:0]    dir_rd_owner_id_i,
  input  logic [WAYS-1:0]       dir_rd_dirty_i,
  output logic                  dir_we_o,
  output logic [SW-1:0]         dir_wr_set_o,
  output logic [WW-1:0]         dir_wr_way_o,
  output logic                  dir_wr_valid_o,
  output logic [CORES-1:0]      dir_wr_sharers_o,
  output logic                  dir_wr_owner_valid_o,
  output logic [OW-1:0]         dir_wr_owner_id_o,
  output logic                  dir_wr_dirty_o,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_UPDATE, S_RESP} state_t;

  localparam logic [2:0] OP_READ       = 3'd0;
  localparam logic [2:0] OP_ADD_SHARER = 3'd1;
  localparam logic [2:0] OP_REMOVE     = 3'd2;
  localparam logic [2:0] OP_SET_OWNER  = 3'd3;
  localparam logic [2:0] OP_INVALIDATE = 3'd4;
  localparam logic [2:0] OP_MARK_DIRTY = 3'd5;

  state_t          state;
  logic [SW-1:0]   set_cnt;
  logic [WW-1:0]   way_cnt;
  logic [SW-1:0]   set_q;
  logic [WW-1:0]   way_q;
  logic [2:0]      op_q;
  logic [OW-1:0]   core_q;
  logic            dirty_q;

  logic            old_v, old_ov, old_d;
  logic [CORES-1:0] old_sh;
  logic [OW-1:0]   old_id;
  logic            new_v, new_ov, new_d;
  logic [CORES-1:0] new_sh;
  logic [OW-1:0]   new_id;
  logic            upd_we, upd_err, owned_by_core;

  assign old_v  = dir_rd_valid_i[way_q];
  assign old_sh = dir_rd_sharers_i[way_q*CORES +: CORES];
  assign old_ov = dir_rd_owner_valid_i[way_q];
  assign old_id = dir_rd_owner_id_i[way_q*OW +: OW];
  assign old_d  = dir_rd_dirty_i[way_q];
  assign owned_by_core = old_ov && (old_id == core_q);

  // New entry starts as the old one so untouched fields are written back as-is.
  always_comb begin
    new_v   = old_v;
    new_sh  = old_sh;
    new_ov  = old_ov;
    new_id  = old_id;
    new_d   = old_d;
    upd_we  = 1'b0;
    upd_err = 1'b0;
    case (op_q)
      OP_READ: ;
      OP_ADD_SHARER: begin
        upd_we = 1'b1;
        new_v  = 1'b1;
        new_sh = old_sh | (CORES'(1) << core_q);
        if (old_ov) begin
          new_sh = old_sh | (CORES'(1) << core_q) | (CORES'(1) << old_id);
          new_ov = 1'b0;
          new_d  = 1'b0;
        end
      end
      OP_REMOVE: begin
        upd_we = 1'b1;
        new_sh = old_sh & ~(CORES'(1) << core_q);
        if (owned_by_core) begin
          new_ov = 1'b0;
          new_d  = 1'b0;
        end
      end
      OP_SET_OWNER: begin
        upd_we = 1'b1;
        new_v  = 1'b1;
        new_sh = '0;
        new_ov = 1'b1;
        new_id = core_q;
        new_d  = dirty_q;
      end
      OP_INVALIDATE: begin
        upd_we = 1'b1;
        new_v  = 1'b0;
        new_sh = '0;
        new_ov = 1'b0;
        new_id = '0;
        new_d  = 1'b0;
      end
      OP_MARK_DIRTY: begin
        if (owned_by_core) begin
          upd_we = 1'b1;
          new_d  = 1'b1;
        end else begin
          upd_err = 1'b1;
        end
      end
      default: upd_err = 1'b1;
    endcase
  end

  assign req_ready_o  = (state == S_IDLE);
  assign dir_rd_set_o = set_q;
  assign dbg_state    = state;

  // Write enable is qualified with rst_n so a reset landing mid-sweep or
  // mid-update never lets a write escape while reset is held.
  always_comb begin
    dir_we_o             = 1'b0;
    dir_wr_set_o         = set_cnt;
    dir_wr_way_o         = way_cnt;
    dir_wr_valid_o       = 1'b0;
    dir_wr_sharers_o     = '0;
    dir_wr_owner_valid_o = 1'b0;
    dir_wr_owner_id_o    = '0;
    dir_wr_dirty_o       = 1'b0;
    if (state == S_INIT) begin
      dir_we_o = rst_n;
    end else if (state == S_UPDATE) begin
      dir_we_o             = rst_n && upd_we;
      dir_wr_set_o         = set_q;
      dir_wr_way_o         = way_q;
      dir_wr_valid_o       = new_v;
      dir_wr_sharers_o     = new_sh;
      dir_wr_owner_valid_o = new_ov;
      dir_wr_owner_id_o    = new_id;
      dir_wr_dirty_o       = new_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_INIT;
      set_cnt           <= '0;
      way_cnt           <= '0;
      init_done_o       <= 1'b0;
      set_q             <= '0;
      way_q             <= '0;
      op_q              <= '0;
      core_q            <= '0;
      dirty_q           <= 1'b0;
      rsp_valid_o       <= 1'b0;
      rsp_valid_st_o    <= 1'b0;
      rsp_sharers_o     <= '0;
      rsp_owner_valid_o <= 1'b0;
      rsp_owner_id_o    <= '0;
      rsp_dirty_o       <= 1'b0;
      rsp_err_o         <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (way_cnt == WW'(WAYS - 1)) begin
            way_cnt <= '0;
            if (set_cnt == SW'(SETS - 1)) begin
              set_cnt     <= '0;
              init_done_o <= 1'b1;
              state       <= S_IDLE;
            end else begin
              set_cnt <= set_cnt + 1'b1;
            end
          end else begin
            way_cnt <= way_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (req_valid_i) begin
            set_q   <= req_set_i;
            way_q   <= req_way_i;
            op_q    <= req_op_i;
            core_q  <= req_core_i;
            dirty_q <= req_dirty_i;
            state   <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          rsp_valid_st_o    <= old_v;
          rsp_sharers_o     <= old_sh;
          rsp_owner_valid_o <= old_ov;
          rsp_owner_id_o    <= old_id;
          rsp_dirty_o       <= old_d;
          rsp_err_o         <= upd_err;
          rsp_valid_o       <= 1'b1;
          state             <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_rv64g_l2_dir_update.sv
// Bench for rv64g_l2_dir_update on a 4-set x 2-way, 4-core directory held in
// bench memory; expected entries come from an op-level model of the directory.
module tb_rv64g_l2_dir_update;

  localparam int SETS  = 4;
  localparam int WAYS  = 2;
  localparam int CORES = 4;
  localparam int OW    = 2;

  typedef struct packed {
    logic             v;
    logic [CORES-1:0] sh;
    logic             ov;
    logic [OW-1:0]    id;
    logic             d;
  } entry_t;

  logic clk, rst_n;
  logic req_valid_i, req_ready_o, req_dirty_i;
  logic [1:0] req_set_i;
  logic [0:0] req_way_i;
  logic [2:0] req_op_i;
  logic [OW-1:0] req_core_i;
  logic rsp_valid_o, rsp_ready_i, rsp_valid_st_o, rsp_owner_valid_o, rsp_dirty_o, rsp_err_o;
  logic [CORES-1:0] rsp_sharers_o;
  logic [OW-1:0] rsp_owner_id_o;
  logic init_done_o;
  logic [1:0] dir_rd_set_o;
  logic [WAYS-1:0] dir_rd_valid_i, dir_rd_owner_valid_i, dir_rd_dirty_i;
  logic [WAYS*CORES-1:0] dir_rd_sharers_i;
  logic [WAYS*OW-1:0] dir_rd_owner_id_i;
  logic dir_we_o, dir_wr_valid_o, dir_wr_owner_valid_o, dir_wr_dirty_o;
  logic [1:0] dir_wr_set_o;
  logic [0:0] dir_wr_way_o;
  logic [CORES-1:0] dir_wr_sharers_o;
  logic [OW-1:0] dir_wr_owner_id_o;
  logic [1:0] dbg_state;

  rv64g_l2_dir_update #(.SETS(SETS), .WAYS(WAYS), .CORES(CORES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_set_i(req_set_i), .req_way_i(req_way_i), .req_op_i(req_op_i),
    .req_core_i(req_core_i), .req_dirty_i(req_dirty_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_valid_st_o(rsp_valid_st_o), .rsp_sharers_o(rsp_sharers_o),
    .rsp_owner_valid_o(rsp_owner_valid_o), .rsp_owner_id_o(rsp_owner_id_o),
    .rsp_dirty_o(rsp_dirty_o), .rsp_err_o(rsp_err_o), .init_done_o(init_done_o),
    .dir_rd_set_o(dir_rd_set_o), .dir_rd_valid_i(dir_rd_valid_i),
    .dir_rd_sharers_i(dir_rd_sharers_i), .dir_rd_owner_valid_i(dir_rd_owner_valid_i),
    .dir_rd_owner_id_i(dir_rd_owner_id_i), .dir_rd_dirty_i(dir_rd_dirty_i),
    .dir_we_o(dir_we_o), .dir_wr_set_o(dir_wr_set_o), .dir_wr_way_o(dir_wr_way_o),
    .dir_wr_valid_o(dir_wr_valid_o), .dir_wr_sharers_o(dir_wr_sharers_o),
    .dir_wr_owner_valid_o(dir_wr_owner_valid_o), .dir_wr_owner_id_o(dir_wr_owner_id_o),
    .dir_wr_dirty_o(dir_wr_dirty_o), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // directory storage that the DUT reads and writes
  entry_t mem [SETS][WAYS];
  logic scramble = 1'b0;

  always @(posedge clk) begin
    if (scramble) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          mem[s][w] <= entry_t'($urandom_range(1, 511));
    end else if (dir_we_o) begin
      mem[dir_wr_set_o][dir_wr_way_o] <= '{v: dir_wr_valid_o, sh: dir_wr_sharers_o,
        ov: dir_wr_owner_valid_o, id: dir_wr_owner_id_o, d: dir_wr_dirty_o};
    end
  end

  always_comb begin
    dir_rd_valid_i       = '0;
    dir_rd_sharers_i     = '0;
    dir_rd_owner_valid_i = '0;
    dir_rd_owner_id_i    = '0;
    dir_rd_dirty_i       = '0;
    for (int w = 0; w < WAYS; w++) begin
      dir_rd_valid_i[w]                 = mem[dir_rd_set_o][w].v;
      dir_rd_sharers_i[w*CORES +: CORES] = mem[dir_rd_set_o][w].sh;
      dir_rd_owner_valid_i[w]           = mem[dir_rd_set_o][w].ov;
      dir_rd_owner_id_i[w*OW +: OW]     = mem[dir_rd_set_o][w].id;
      dir_rd_dirty_i[w]                 = mem[dir_rd_set_o][w].d;
    end
  end

  // reference model: directory contents as the protocol rules say they should be
  entry_t model [SETS][WAYS];

  function automatic void model_op(input entry_t o, input logic [2:0] op,
                                   input logic [OW-1:0] c, input logic dty,
                                   output entry_t n, output logic we, output logic err);
    logic owns;
    owns = o.ov && (o.id == c);
    n = o;
    we = 1'b1;
    err = 1'b0;
    case (op)
      3'd0: we = 1'b0;
      3'd1: begin
        n.v = 1'b1;
        n.sh[c] = 1'b1;
        if (o.ov) begin
          n.sh[o.id] = 1'b1;
          n.ov = 1'b0;
          n.d = 1'b0;
        end
      end
      3'd2: begin
        n.sh[c] = 1'b0;
        if (owns) begin
          n.ov = 1'b0;
          n.d = 1'b0;
        end
      end
      3'd3: n = '{v: 1'b1, sh: '0, ov: 1'b1, id: c, d: dty};
      3'd4: n = '0;
      3'd5: begin
        if (owns) n.d = 1'b1;
        else begin
          we = 1'b0;
          err = 1'b1;
        end
      end
      default: begin
        we = 1'b0;
        err = 1'b1;
      end
    endcase
  endfunction

  function automatic entry_t rsp_entry();
    return '{v: rsp_valid_st_o, sh: rsp_sharers_o, ov: rsp_owner_valid_o,
             id: rsp_owner_id_o, d: rsp_dirty_o};
  endfunction

  function automatic entry_t wr_entry();
    return '{v: dir_wr_valid_o, sh: dir_wr_sharers_o, ov: dir_wr_owner_valid_o,
             id: dir_wr_owner_id_o, d: dir_wr_dirty_o};
  endfunction

  // driver: one request through accept, update, response; called at a negedge in IDLE
  task automatic do_txn(input int s, input int w, input logic [2:0] op,
                        input logic [OW-1:0] c, input logic dty, input int hold,
                        output int acc_cyc);
    entry_t pre, nxt;
    logic ewe, eerr;
    pre = model[s][w];
    model_op(pre, op, c, dty, nxt, ewe, eerr);
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL txn_ready: got %b expected 1", req_ready_o);
    end
    req_valid_i = 1'b1;
    req_set_i   = 2'(s);
    req_way_i   = 1'(w);
    req_op_i    = op;
    req_core_i  = c;
    req_dirty_i = dty;
    @(negedge clk);
    acc_cyc = cyc;
    req_valid_i = 1'b0;
    checks++;
    if (dir_we_o !== ewe) begin
      errors++;
      $display("FAIL upd_we op%0d: got %b expected %b", op, dir_we_o, ewe);
    end
    if (ewe) begin
      checks++;
      if ({dir_wr_set_o, dir_wr_way_o, wr_entry()} !== {2'(s), 1'(w), nxt}) begin
        errors++;
        $display("FAIL upd_wdata op%0d: got %h/%h/%h expected %h/%h/%h", op,
                 dir_wr_set_o, dir_wr_way_o, wr_entry(), s, w, nxt);
      end
    end
    checks++;
    if ({req_ready_o, rsp_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL upd_hs: got ready=%b rsp_valid=%b expected 0/0", req_ready_o, rsp_valid_o);
    end
    @(negedge clk);
    for (int k = 0; k <= hold; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if ({rsp_valid_o, req_ready_o, dir_we_o, rsp_err_o, rsp_entry()} !== {3'b100, eerr, pre}) begin
        errors++;
        $display("FAIL resp op%0d cyc%0d: got v=%b rdy=%b we=%b err=%b e=%h expected 1/0/0/%b/%h",
                 op, k, rsp_valid_o, req_ready_o, dir_we_o, rsp_err_o, rsp_entry(), eerr, pre);
      end
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    checks++;
    if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL resp_done: got rsp_valid=%b ready=%b expected 0/1", rsp_valid_o, req_ready_o);
    end
    model[s][w] = nxt;
    checks++;
    if (mem[s][w] !== nxt) begin
      errors++;
      $display("FAIL dir_entry s%0d w%0d: got %h expected %h", s, w, mem[s][w], nxt);
    end
  endtask

  // called at the negedge where rst_n has just been released
  task automatic check_sweep();
    int bad;
    for (int i = 0; i < SETS * WAYS; i++) begin
      #1;
      checks++;
      if ({dir_we_o, dir_wr_set_o, dir_wr_way_o, wr_entry(), init_done_o, req_ready_o} !==
          {1'b1, 2'(i / WAYS), 1'(i % WAYS), 9'b0, 2'b00}) begin
        errors++;
        $display("FAIL sweep_%0d: got we=%b s=%0d w=%0d e=%h done=%b rdy=%b expected 1/%0d/%0d/0/0/0",
                 i, dir_we_o, dir_wr_set_o, dir_wr_way_o, wr_entry(), init_done_o, req_ready_o,
                 i / WAYS, i % WAYS);
      end
      @(negedge clk);
    end
    checks++;
    if ({init_done_o, req_ready_o, dir_we_o} !== 3'b110) begin
      errors++;
      $display("FAIL sweep_end: got done=%b ready=%b we=%b expected 1/1/0",
               init_done_o, req_ready_o, dir_we_o);
    end
    bad = 0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        if (mem[s][w] !== '0) bad++;
        model[s][w] = '0;
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sweep_zero: got %0d nonzero entries expected 0", bad);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    scramble = 1'b1;
    repeat (2) @(negedge clk);
    scramble = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready_o, rsp_valid_o, rsp_err_o, dir_we_o, init_done_o, rsp_entry()} !== 14'b0) begin
      errors++;
      $display("FAIL reset_outs: got rdy=%b rv=%b err=%b we=%b done=%b e=%h expected all 0",
               req_ready_o, rsp_valid_o, rsp_err_o, dir_we_o, init_done_o, rsp_entry());
    end
    rst_n = 1'b1;
    check_sweep();
  endtask

  task automatic test_directed();
    int a;
    do_txn(1, 0, 3'd3, 2'd2, 1'b1, 0, a);
    checks++;
    if (mem[1][0] !== 9'b1_0000_1_10_1) begin
      errors++;
      $display("FAIL set_owner_entry: got %h expected %h", mem[1][0], 9'b1_0000_1_10_1);
    end
    do_txn(1, 0, 3'd1, 2'd1, 1'b0, 0, a);
    checks++;
    if (mem[1][0] !== 9'b1_0110_0_10_0) begin
      errors++;
      $display("FAIL add_sharer_entry: got %h expected %h", mem[1][0], 9'b1_0110_0_10_0);
    end
    do_txn(2, 1, 3'd3, 2'd2, 1'b1, 0, a);
    do_txn(2, 1, 3'd2, 2'd2, 1'b0, 0, a);
    checks++;
    if (mem[2][1] !== 9'b1_0000_0_10_0) begin
      errors++;
      $display("FAIL remove_owner_entry: got %h expected %h", mem[2][1], 9'b1_0000_0_10_0);
    end
    do_txn(3, 0, 3'd3, 2'd2, 1'b0, 0, a);
    do_txn(3, 0, 3'd5, 2'd3, 1'b0, 0, a);
    do_txn(3, 0, 3'd5, 2'd2, 1'b0, 0, a);
    do_txn(3, 1, 3'd7, 2'd0, 1'b0, 0, a);
    do_txn(3, 1, 3'd6, 2'd1, 1'b1, 0, a);
  endtask

  task automatic test_stall();
    int a;
    do_txn(0, 1, 3'd3, 2'd1, 1'b1, 0, a);
    do_txn(0, 1, 3'd0, 2'd0, 1'b0, 5, a);
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2;
    do_txn(1, 1, 3'd1, 2'd0, 1'b0, 0, a0);
    do_txn(1, 1, 3'd1, 2'd3, 1'b0, 0, a1);
    do_txn(1, 1, 3'd4, 2'd0, 1'b0, 0, a2);
    checks++;
    if ((a1 - a0) != 3 || (a2 - a1) != 3) begin
      errors++;
      $display("FAIL accept_spacing: got %0d,%0d expected 3,3", a1 - a0, a2 - a1);
    end
  endtask

  task automatic test_random();
    int a;
    for (int n = 0; n < 80; n++)
      do_txn($urandom_range(0, SETS - 1), $urandom_range(0, WAYS - 1),
             3'($urandom_range(0, 7)), 2'($urandom_range(0, CORES - 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 2), a);
  endtask

  task automatic test_reset_mid();
    req_valid_i = 1'b1;
    req_set_i   = 2'd2;
    req_way_i   = 1'd0;
    req_op_i    = 3'd3;
    req_core_i  = 2'd1;
    req_dirty_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dir_we_o, rsp_valid_o, req_ready_o, init_done_o, rsp_err_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid: got we=%b rv=%b rdy=%b done=%b err=%b expected all 0",
               dir_we_o, rsp_valid_o, req_ready_o, init_done_o, rsp_err_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_sweep();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req_valid_i = 1'b0;
    req_set_i = '0;
    req_way_i = '0;
    req_op_i = '0;
    req_core_i = '0;
    req_dirty_i = 1'b0;
    rsp_ready_i = 1'b0;
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv64g_l2_dir_update.md
RV64G_L2_DIR_UPDATE -- requirements
Module: rv64g_l2_dir_update

Interface
REQ-001 SHALL have parameter SETS, default 256, number of directory sets.
REQ-002 SHALL have parameter WAYS, default 16, number of ways per set.
REQ-003 SHALL have parameter CORES, default 4, number of cores; OW = $clog2(CORES).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid_i / req_ready_o  in/out  1/1  request handshake.
REQ-007 SHALL have port req_set_i  in  $clog2(SETS)  target set.
REQ-008 SHALL have port req_way_i  in  $clog2(WAYS)  target way.
REQ-009 SHALL have port req_op_i  in  3  opcode: 0 READ, 1 ADD_SHARER, 2 REMOVE, 3 SET_OWNER, 4 INVALIDATE, 5 MARK_DIRTY, 6-7 illegal.
REQ-010 SHALL have port req_core_i / req_dirty_i  in  OW/1  core id; dirty value for SET_OWNER.
REQ-011 SHALL have port rsp_valid_o / rsp_ready_i  out/in  1/1  response handshake.
REQ-012 SHALL have port rsp_valid_st_o, rsp_sharers_o, rsp_owner_valid_o, rsp_owner_id_o, rsp_dirty_o  out  1/CORES/1/OW/1  pre-update entry of the target way.
REQ-013 SHALL have port rsp_err_o  out  1  illegal op or refused MARK_DIRTY.
REQ-014 SHALL have port init_done_o  out  1  directory sweep complete.
REQ-015 SHALL have port dir_rd_set_o  out  $clog2(SETS)  directory read set; read data returns combinationally in the same cycle.
REQ-016 SHALL have ports dir_rd_valid_i, dir_rd_sharers_i, dir_rd_owner_valid_i, dir_rd_owner_id_i, dir_rd_dirty_i  in  WAYS/WAYS*CORES/WAYS/WAYS*OW/WAYS  whole-set read data.
REQ-017 SHALL have ports dir_we_o, dir_wr_set_o, dir_wr_way_o, dir_wr_valid_o, dir_wr_sharers_o, dir_wr_owner_valid_o, dir_wr_owner_id_o, dir_wr_dirty_o  out  1/set/way/1/CORES/1/OW/1  directory write port.

Function
REQ-018 SHALL implement FSM states INIT, IDLE, UPDATE, RESP; reset state INIT.
REQ-019 INIT SHALL write an all-zero entry each cycle, way counter inner and set counter outer, starting at set 0/way 0; after set SETS-1/way WAYS-1 it SHALL go to IDLE and set init_done_o=1, which then stays 1 until reset.
REQ-020 req_ready_o SHALL be 1 only in IDLE; a request is accepted when req_valid_i && req_ready_o, and all fields SHALL be latched.
REQ-021 UPDATE (accept cycle +1) SHALL drive dir_rd_set_o = latched set, capture the target way's entry into the rsp_* registers, and assert dir_we_o for one cycle when the op writes.
REQ-022 ADD_SHARER SHALL write valid=1, sharers = old|bit(core); if old owner_valid, sharers |= bit(old owner_id), owner_valid=0, dirty=0.
REQ-023 REMOVE SHALL clear bit(core); if owner_valid && owner_id==core, owner_valid=0 and dirty=0; valid SHALL be unchanged.
REQ-024 SET_OWNER SHALL write valid=1, owner_valid=1, owner_id=core, sharers=0, dirty=req_dirty_i.
REQ-025 INVALIDATE SHALL write an all-zero entry.
REQ-026 MARK_DIRTY SHALL set dirty=1 only when old owner_valid && owner_id==core; otherwise it SHALL not write and SHALL set rsp_err_o=1.
REQ-027 READ and illegal ops SHALL not write; illegal ops SHALL set rsp_err_o=1.
REQ-028 Fields not named by an op SHALL be written back unchanged.
REQ-029 RESP SHALL hold rsp_valid_o=1 with stable data until rsp_ready_i, then go to IDLE; minimum accept-to-accept spacing SHALL be 3 cycles.
REQ-030 dir_we_o SHALL be 0 in IDLE and RESP.

Reset
REQ-031 Assertion of rst_n low SHALL immediately force INIT, clear the counters, and drive req_ready_o=0, rsp_valid_o=0, rsp_err_o=0, dir_we_o=0, init_done_o=0 and all rsp_* fields 0.
REQ-032 Reset in any state, including mid-sweep or RESP, SHALL discard the pending request and restart the sweep from set 0/way 0.

Verification
REQ-033 With SETS=4, WAYS=2, release reset -> exactly 8 consecutive zero writes (set,way)=(0,0)..(3,1); init_done_o=1 and req_ready_o=1 on the cycle after the last write.
REQ-034 SET_OWNER set1 way0 core2 dirty1 -> write {v1,sh0,ov1,id2,d1}; rsp returns all zeros; then ADD_SHARER core1 -> write sharers=4'b0110, ov0, d0.
REQ-035 REMOVE core2 on {ov1,id2,d1} -> write ov0, d0, sharers 0, valid 1.
REQ-036 MARK_DIRTY core3 on owner core2 -> no dir_we_o, rsp_err_o=1; op 7 -> no write, rsp_err_o=1.
REQ-037 Hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o and data stable, req_ready_o=0 throughout.
REQ-038 Pulse rst_n low during UPDATE -> no write issued, rsp_valid_o=0, sweep restarts at (0,0).
